mc_bus_slave: RTL and testbench

- Clock-domain front end for the MCU parallel memory-controller bus (mc_ce/mc_we/mc_oe/mc_add, 16-bit data).
- Sits between the top-level mc_data SB_IO tristate array and the internal peripheral logic.
- Consumes mc_din from the SB_IO block and produces mc_dout and its output-enable.
- Synchronises the asynchronous strobes, queues MCU writes into a command FIFO, services reads through a request/response port, and exposes a status register.

---
 rtl/mc_bus_slave.sv | 217 +++++++++++++++++++++
 tb/tb_mc_bus_slave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_slave.sv
// mc_bus_slave: MCU parallel-bus front end. Synchronises the asynchronous
// strobes, queues MCU writes into a first-word-fall-through command FIFO,
// forwards peripheral reads through a request/response port and answers
// reads of STATUS_ADDR locally with {overflow, pad, fifo_count}.
module mc_bus_slave #(
   parameter int                   DATA_WIDTH  = 16,
   parameter int                   ADD_WIDTH   = 6,
   parameter int                   FIFO_DEPTH  = 8,
   parameter logic [ADD_WIDTH-1:0] STATUS_ADDR = 6'h3F
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mc_ce,
   input  logic                  mc_we,
   input  logic                  mc_oe,
   input  logic [ADD_WIDTH-1:0]  mc_add,
   input  logic [DATA_WIDTH-1:0] mc_din,
   output logic [DATA_WIDTH-1:0] mc_dout,
   output logic                  mc_dout_en,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADD_WIDTH-1:0]  cmd_addr,
   output logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rd_req,
   output logic [ADD_WIDTH-1:0]  rd_addr,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int PAD_W = DATA_WIDTH - 1 - CNT_W;
   localparam int ENT_W = ADD_WIDTH + DATA_WIDTH;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WRITE     = 2'd1;
   localparam logic [1:0] ST_READ_WAIT = 2'd2;
   localparam logic [1:0] ST_READ_HOLD = 2'd3;

   // synchroniser, history and arming state
   logic       ce_m_q, ce_s_q, we_m_q, we_s_q, oe_m_q, oe_s_q;
   logic       we_h_q, oe_h_q, we_armed_q;
   logic [1:0] settle_q;
   logic       trusted, we_rise, oe_fall;

   // FSM and datapath state
   logic [1:0]            state_q, state_d;
   logic                  status_rd, rd_start, rd_done;
   logic                  rd_req_q, dout_en_q;
   logic [ADD_WIDTH-1:0]  rd_addr_q, stage_addr_q;
   logic [DATA_WIDTH-1:0] dout_q, stage_data_q;

   // FIFO state
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             fifo_empty, fifo_full, commit, push, pop, drop;
   logic [ENT_W-1:0] head_w;
   logic [DATA_WIDTH-1:0] status_word;

   // Right after reset the chain still holds its reset value of 1, not the pin,
   // so history/arming only load once two clean samples have passed. This keeps
   // a strobe that is already low at release from looking like a fresh edge.
   assign trusted = settle_q[1];
   assign we_rise = we_s_q & ~we_h_q;
   assign oe_fall = oe_h_q & ~oe_s_q;

   // two-flop synchronisers plus history/arming flops for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ce_m_q     <= 1'b1;
         ce_s_q     <= 1'b1;
         we_m_q     <= 1'b1;
         we_s_q     <= 1'b1;
         oe_m_q     <= 1'b1;
         oe_s_q     <= 1'b1;
         we_h_q     <= 1'b0;
         oe_h_q     <= 1'b0;
         we_armed_q <= 1'b0;
         settle_q   <= 2'b00;
      end else begin
         ce_m_q   <= mc_ce;
         ce_s_q   <= ce_m_q;
         we_m_q   <= mc_we;
         we_s_q   <= we_m_q;
         oe_m_q   <= mc_oe;
         oe_s_q   <= oe_m_q;
         settle_q <= {settle_q[0], 1'b1};
         if (trusted) begin
            we_h_q <= we_s_q;
            oe_h_q <= oe_s_q;
            if (we_s_q) begin
               we_armed_q <= 1'b1;
            end
         end
      end
   end

   // next-state logic; a low write strobe masks any oe edge
   always_comb begin
      state_d   = state_q;
      status_rd = 1'b0;
      rd_start  = 1'b0;
      rd_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!we_s_q && !ce_s_q && we_armed_q) begin
               state_d = ST_WRITE;
            end else if (oe_fall && !ce_s_q && we_s_q) begin
               if (mc_add == STATUS_ADDR) begin
                  status_rd = 1'b1;
                  state_d   = ST_READ_HOLD;
               end else begin
                  rd_start = 1'b1;
                  state_d  = ST_READ_WAIT;
               end
            end
         end
         ST_WRITE: begin
            if (we_rise) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ_WAIT: begin
            if (oe_s_q || ce_s_q) begin
               state_d = ST_IDLE;
            end else if (rd_valid) begin
               rd_done = 1'b1;
               state_d = ST_READ_HOLD;
            end
         end
         ST_READ_HOLD: begin
            if (oe_s_q || ce_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign status_word = {ovf_q, {PAD_W{1'b0}}, count_q};

   // state, read-port registers, output data/enable and write staging
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         dout_q       <= '0;
         dout_en_q    <= 1'b0;
         stage_addr_q <= '0;
         stage_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_req_q  <= rd_start;
         dout_en_q <= (state_d == ST_READ_WAIT) || (state_d == ST_READ_HOLD);
         if (rd_start) begin
            rd_addr_q <= mc_add;
         end
         if (status_rd) begin
            dout_q <= status_word;
         end else if (rd_done) begin
            dout_q <= rd_data;
         end
         if (state_q == ST_WRITE) begin
            stage_addr_q <= mc_add;
            stage_data_q <= mc_din;
         end
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign commit     = (state_q == ST_WRITE) && we_rise;
   assign pop        = !fifo_empty && cmd_ready;
   assign push       = commit && (!fifo_full || pop);
   assign drop       = commit && fifo_full && !pop;

   // FIFO pointers, occupancy and sticky overflow (a same-cycle drop wins over a clear)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         ovf_q <= drop | (ovf_q & ~status_rd);
      end
   end

   // FIFO storage; contents need no reset because the head is masked while empty
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {stage_addr_q, stage_data_q};
      end
   end

   assign head_w     = fifo_mem[rd_ptr_q];
   assign cmd_valid  = !fifo_empty;
   assign cmd_addr   = fifo_empty ? '0 : head_w[ENT_W-1:DATA_WIDTH];
   assign cmd_data   = fifo_empty ? '0 : head_w[DATA_WIDTH-1:0];
   assign rd_req     = rd_req_q;
   assign rd_addr    = rd_addr_q;
   assign mc_dout    = dout_q;
   assign mc_dout_en = dout_en_q;
endmodule

// File: tb/tb_mc_bus_slave.sv
// Bench for mc_bus_slave: a vector table for the overflow scenario, hand
// sequences for the multi-cycle corners and a random run against a queue model.
module tb_mc_bus_slave;
   logic        clock, reset;
   logic        mc_ce, mc_we, mc_oe;
   logic [5:0]  mc_add;
   logic [15:0] mc_din, mc_dout;
   logic        mc_dout_en, cmd_valid, cmd_ready;
   logic [5:0]  cmd_addr, rd_addr;
   logic [15:0] cmd_data, rd_data;
   logic        rd_req, rd_valid;

   mc_bus_slave dut (
      .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
      .mc_add(mc_add), .mc_din(mc_din), .mc_dout(mc_dout), .mc_dout_en(mc_dout_en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int nvec = 0;
   int errors = 0;
   int req_count = 0;

   // reference model: queue of {addr,data}, sticky overflow, last read data
   logic [21:0] mq[$];
   bit          m_ovf = 1'b0;
   logic [15:0] m_dout = '0;

   always @(negedge clock) if (rd_req === 1'b1) req_count++;

   typedef struct {
      logic [1:0]  op;        // 0 write, 1 status read, 2 pop
      logic [5:0]  addr;
      logic [15:0] data;
      logic        exp_valid;
      logic [5:0]  exp_addr;
      logic [15:0] exp_head;
      logic [15:0] exp_dout;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_head(input string name);
      check({name, "_valid"}, cmd_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check({name, "_addr"}, cmd_addr, mq[0][21:16]);
         check({name, "_data"}, cmd_data, mq[0][15:0]);
      end
   endtask

   task automatic wait_req(output bit seen);
      int n = 0;
      while (rd_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      seen = (rd_req === 1'b1);
   endtask

   // full MCU write; optionally pulses cmd_ready across the commit edge
   task automatic do_write(input logic [5:0] a, input logic [15:0] d, input bit pop_at_commit);
      bit popped;
      mc_add = a; mc_din = d; mc_ce = 1'b0;
      tick();
      mc_we = 1'b0;
      repeat (5) tick();
      mc_we = 1'b1;
      tick();
      tick();
      if (pop_at_commit) cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      popped = pop_at_commit && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (mq.size() >= 8) m_ovf = 1'b1;
      else mq.push_back({a, d});
      mc_ce = 1'b1;
      repeat (3) tick();
   endtask

   task automatic do_pop();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic do_status(output logic [15:0] got, output logic [15:0] exp);
      int base = req_count;
      mc_add = 6'h3F; mc_ce = 1'b0;
      tick();
      mc_oe = 1'b0;
      repeat (5) tick();
      got = mc_dout;
      exp = {m_ovf, 11'd0, 4'(mq.size())};
      check("st_dout_en", mc_dout_en, 1'b1);
      m_ovf = 1'b0;
      m_dout = exp;
      mc_oe = 1'b1;
      repeat (4) tick();
      check("st_en_off", mc_dout_en, 1'b0);
      check("st_no_req", req_count - base, 0);
      mc_ce = 1'b1;
      tick();
   endtask

   task automatic do_periph(input logic [5:0] a, input int lat, input logic [15:0] d, input bit abandon);
      int base = req_count;
      bit seen;
      mc_add = a; mc_ce = 1'b0;
      tick();
      mc_oe = 1'b0;
      wait_req(seen);
      check("pr_req_seen", seen, 1'b1);
      check("pr_rd_addr", rd_addr, a);
      check("pr_en_on", mc_dout_en, 1'b1);
      tick();
      check("pr_req_pulse", rd_req, 1'b0);
      if (abandon) begin
         mc_oe = 1'b1;
         repeat (4) tick();
         check("ab_en_off", mc_dout_en, 1'b0);
         rd_data = 16'hFFFF; rd_valid = 1'b1;
         tick();
         rd_valid = 1'b0;
         tick();
         check("ab_dout_kept", mc_dout, m_dout);
      end else begin
         repeat (lat) tick();
         rd_data = d; rd_valid = 1'b1;
         tick();
         rd_valid = 1'b0;
         tick();
         m_dout = d;
         check("pr_dout", mc_dout, d);
         check("pr_en_hold", mc_dout_en, 1'b1);
         mc_oe = 1'b1;
         repeat (4) tick();
         check("pr_en_off", mc_dout_en, 1'b0);
         check("pr_dout_keep", mc_dout, d);
      end
      check("pr_req_count", req_count - base, 1);
      mc_ce = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got, exp;
      bit seen;
      int n, base;

      reset = 1'b1; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
      mc_add = '0; mc_din = '0; cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;

      // overflow scenario table
      for (int i = 0; i < 9; i++)
         vecs.push_back('{2'd0, 6'(6'h10 + i), 16'(i + 1), 1'b1, 6'h10, 16'h0001, 16'h0000});
      vecs.push_back('{2'd1, 6'h3F, 16'h0, 1'b1, 6'h10, 16'h0001, 16'h8008});
      vecs.push_back('{2'd1, 6'h3F, 16'h0, 1'b1, 6'h10, 16'h0001, 16'h0008});
      for (int k = 1; k <= 8; k++)
         vecs.push_back('{2'd2, 6'h0, 16'h0, k < 8, (k < 8) ? 6'(6'h10 + k) : 6'h0,
                          (k < 8) ? 16'(k + 1) : 16'h0, 16'h0000});

      // reset state
      repeat (2) tick();
      check("rst_dout", mc_dout, 16'h0);
      check("rst_dout_en", mc_dout_en, 1'b0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_rd_req", rd_req, 1'b0);
      check("rst_rd_addr", rd_addr, 6'h0);
      reset = 1'b0;
      repeat (4) tick();
      $display("txn reset released");

      // basic write with commit latency
      mc_add = 6'h05; mc_din = 16'hA5C3; mc_ce = 1'b0;
      tick();
      mc_we = 1'b0;
      repeat (6) tick();
      mc_we = 1'b1;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check("wr_latency_3_4", (n >= 3) && (n <= 4), 1'b1);
      check("wr_cmd_addr", cmd_addr, 6'h05);
      check("wr_cmd_data", cmd_data, 16'hA5C3);
      mc_ce = 1'b1;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("wr_popped", cmd_valid, 1'b0);
      repeat (3) tick();
      $display("txn basic write latency=%0d", n);

      // table-driven overflow run
      foreach (vecs[i]) begin
         case (vecs[i].op)
            2'd0: do_write(vecs[i].addr, vecs[i].data, 1'b0);
            2'd1: begin
               do_status(got, exp);
               check("tbl_status", got, vecs[i].exp_dout);
            end
            default: do_pop();
         endcase
         check("tbl_valid", cmd_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check("tbl_head_addr", cmd_addr, vecs[i].exp_addr);
            check("tbl_head_data", cmd_data, vecs[i].exp_head);
         end
         $display("txn tbl %0d op=%0d addr=%h data=%h", i, vecs[i].op, vecs[i].addr, vecs[i].data);
      end

      // peripheral read then abandoned read
      do_periph(6'h12, 3, 16'h1234, 1'b0);
      $display("txn periph read 12 -> %h", mc_dout);
      do_periph(6'h21, 0, 16'h0, 1'b1);
      $display("txn abandoned read 21");

      // full FIFO with push and pop on the same edge
      for (int i = 0; i < 8; i++) do_write(6'(i), 16'(16'h0100 + i), 1'b0);
      do_write(6'h3E, 16'hCAFE, 1'b1);
      check_head("fullpp");
      check("fullpp_head", cmd_data, 16'h0101);
      do_status(got, exp);
      check("fullpp_status", got, 16'h0008);
      for (int i = 0; i < 7; i++) do_pop();
      check("fullpp_tail_addr", cmd_addr, 6'h3E);
      check("fullpp_tail_data", cmd_data, 16'hCAFE);
      do_pop();
      check_head("fullpp_end");
      $display("txn full push+pop done");

      // reset in the middle of a peripheral read
      do_write(6'h2A, 16'hBEEF, 1'b0);
      check("mr_pre_valid", cmd_valid, 1'b1);
      mc_add = 6'h12; mc_ce = 1'b0;
      tick();
      mc_oe = 1'b0;
      wait_req(seen);
      check("mr_req_seen", seen, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("mr_en_async", mc_dout_en, 1'b0);
      check("mr_req_async", rd_req, 1'b0);
      check("mr_valid_async", cmd_valid, 1'b0);
      mq.delete(); m_ovf = 1'b0; m_dout = '0;
      tick();
      tick();
      reset = 1'b0;
      base = req_count;
      repeat (8) tick();
      check("mr_no_req_held", req_count - base, 0);
      check("mr_en_held", mc_dout_en, 1'b0);
      mc_oe = 1'b1;
      repeat (4) tick();
      mc_oe = 1'b0;
      wait_req(seen);
      check("mr_req_after_toggle", seen, 1'b1);
      rd_data = 16'h5A5A; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      tick();
      check("mr_dout", mc_dout, 16'h5A5A);
      m_dout = 16'h5A5A;
      mc_oe = 1'b1;
      repeat (4) tick();
      mc_ce = 1'b1;
      tick();
      $display("txn reset mid-read done");

      // randomized run against the model
      for (int i = 0; i < 120; i++) begin
         int op;
         logic [5:0] ra;
         logic [15:0] rd;
         op = $urandom_range(0, 9);
         ra = 6'($urandom);
         rd = 16'($urandom);
         if (op < 5) begin
            do_write(ra, rd, 1'b0);
         end else if (op < 7) begin
            do_pop();
         end else if (op < 8) begin
            do_status(got, exp);
            check("rnd_status", got, exp);
         end else begin
            if (ra == 6'h3F) ra = 6'h00;
            do_periph(ra, $urandom_range(0, 4), rd, ($urandom_range(0, 9) == 0));
         end
         check_head("rnd");
         $display("txn rnd %0d op=%0d addr=%h data=%h depth=%0d", i, op, ra, rd, mq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
      $finish;
   end
endmodule
